// File: rtl/router_mp.sv
// router_mp: store-and-forward packet router. Byte-serial packets are buffered,
// validated (size, length, checksum, destination) and forwarded to one of NUM_PORTS outputs.
`timescale 1ns/1ps

module router_mp #(
   parameter int NUM_PORTS = 4,
   parameter int MIN_LEN   = 12,
   parameter int MAX_LEN   = 64,
   parameter int BUF_DEPTH = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             dut_inp,
   input  logic                   inp_valid,
   output logic [8*NUM_PORTS-1:0] dut_outp,
   output logic [NUM_PORTS-1:0]   outp_valid,
   input  logic [NUM_PORTS-1:0]   outp_ready,
   output logic                   busy,
   output logic [3:0]             error,
   output logic [15:0]            drop_cnt
);

   localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CW = 16;

   localparam logic [CW-1:0] MIN_C = CW'(MIN_LEN);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_LEN);
   localparam logic [CW-1:0] BUF_C = CW'(BUF_DEPTH);
   localparam logic [7:0]    NP_C  = 8'(NUM_PORTS);

   localparam logic [3:0] E_NONE  = 4'd0;
   localparam logic [3:0] E_PROTO = 4'd1;
   localparam logic [3:0] E_CRC   = 4'd2;
   localparam logic [3:0] E_SHORT = 4'd3;
   localparam logic [3:0] E_LONG  = 4'd4;
   localparam logic [3:0] E_LEN   = 4'd5;
   localparam logic [3:0] E_DA    = 4'd6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_CHECK,
      S_FWD,
      S_DROP
   } state_t;

   state_t                 state_q;
   logic [CW-1:0]          cnt_q;
   logic [CW-1:0]          rd_q;
   logic [7:0]             da_q;
   logic [31:0]            len_q;
   logic [31:0]            crc_q;
   logic [31:0]            sum_q;
   logic [PW-1:0]          port_q;
   logic                   ign_q;
   logic [NUM_PORTS-1:0]   outp_valid_q;
   logic [8*NUM_PORTS-1:0] dut_outp_q;
   logic                   busy_q;
   logic [3:0]             error_q;
   logic [15:0]            drop_cnt_q;
   logic [7:0]             mem_q [BUF_DEPTH];

   logic                   wr_en;
   logic [AW-1:0]          wr_addr;
   logic [3:0]             chk_code;
   logic [PW-1:0]          port_d;
   logic                   viol;
   logic                   fwd_xfer;
   logic [7:0]             rd_byte;

   assign port_d   = PW'(da_q - 8'd1);
   assign fwd_xfer = outp_valid_q[port_q] & outp_ready[port_q];
   assign rd_byte  = mem_q[rd_q[AW-1:0]];
   assign viol     = inp_valid && !ign_q &&
                     (state_q == S_CHECK || state_q == S_FWD || state_q == S_DROP);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = cnt_q[AW-1:0];
      if (state_q == S_IDLE && inp_valid && !ign_q) begin
         wr_en   = 1'b1;
         wr_addr = '0;
      end else if (state_q == S_RECV && inp_valid && cnt_q < BUF_C) begin
         wr_en = 1'b1;
      end
   end

   // Checks in priority order; the first failure determines the code.
   always_comb begin
      chk_code = E_NONE;
      if (cnt_q < MIN_C)
         chk_code = E_SHORT;
      else if (cnt_q > MAX_C)
         chk_code = E_LONG;
      else if (len_q != {{(32-CW){1'b0}}, cnt_q})
         chk_code = E_LEN;
      else if (crc_q != sum_q)
         chk_code = E_CRC;
      else if (da_q == 8'd0 || da_q > NP_C)
         chk_code = E_DA;
   end

   // NOTE: the packet buffer is plain storage with no reset; every byte is written before it is read.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[wr_addr] <= dut_inp;
   end

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         rd_q         <= '0;
         da_q         <= '0;
         len_q        <= '0;
         crc_q        <= '0;
         sum_q        <= '0;
         port_q       <= '0;
         ign_q        <= 1'b0;
         outp_valid_q <= '0;
         dut_outp_q   <= '0;
         busy_q       <= 1'b0;
         error_q      <= E_NONE;
         drop_cnt_q   <= '0;
      end else begin
         error_q <= E_NONE;
         if (!inp_valid)
            ign_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (inp_valid && !ign_q) begin
                  state_q <= S_RECV;
                  busy_q  <= 1'b1;
                  cnt_q   <= CW'(1);
                  da_q    <= '0;
                  len_q   <= '0;
                  crc_q   <= '0;
                  sum_q   <= '0;
               end
            end

            S_RECV: begin
               if (inp_valid) begin
                  if (cnt_q != '1)
                     cnt_q <= cnt_q + CW'(1);
                  // Header fields are captured by byte index as they stream past.
                  case (cnt_q)
                     16'd1:   da_q         <= dut_inp;
                     16'd2:   len_q[7:0]   <= dut_inp;
                     16'd3:   len_q[15:8]  <= dut_inp;
                     16'd4:   len_q[23:16] <= dut_inp;
                     16'd5:   len_q[31:24] <= dut_inp;
                     16'd6:   crc_q[7:0]   <= dut_inp;
                     16'd7:   crc_q[15:8]  <= dut_inp;
                     16'd8:   crc_q[23:16] <= dut_inp;
                     16'd9:   crc_q[31:24] <= dut_inp;
                     default: sum_q        <= sum_q + {24'd0, dut_inp};
                  endcase
               end else begin
                  state_q <= S_CHECK;
               end
            end

            S_CHECK: begin
               if (chk_code == E_NONE) begin
                  state_q                          <= S_FWD;
                  port_q                           <= port_d;
                  outp_valid_q[port_d]             <= 1'b1;
                  dut_outp_q[8*int'(port_d) +: 8]  <= mem_q[0];
                  rd_q                             <= CW'(1);
               end else begin
                  state_q <= S_DROP;
                  error_q <= chk_code;
                  if (drop_cnt_q != 16'hFFFF)
                     drop_cnt_q <= drop_cnt_q + 16'd1;
               end
            end

            S_FWD: begin
               if (fwd_xfer) begin
                  if (rd_q == cnt_q) begin
                     state_q      <= S_IDLE;
                     busy_q       <= 1'b0;
                     outp_valid_q <= '0;
                     dut_outp_q   <= '0;
                  end else begin
                     dut_outp_q[8*int'(port_q) +: 8] <= rd_byte;
                     rd_q                            <= rd_q + CW'(1);
                  end
               end
            end

            S_DROP: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase

         // A protocol violation overrides any drop code in the same cycle.
         if (viol) begin
            error_q <= E_PROTO;
            ign_q   <= 1'b1;
         end
      end
   end

   assign dut_outp   = dut_outp_q;
   assign outp_valid = outp_valid_q;
   assign busy       = busy_q;
   assign error      = error_q;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_router_mp.sv
// Self-checking bench for router_mp: randomized packets against a byte-level
// reference model with a per-port scoreboard and randomized backpressure.
`timescale 1ns/1ps

module tb_router_mp;

   localparam int NP = 4;

   logic            clk        = 1'b0;
   logic            reset      = 1'b0;
   logic [7:0]      dut_inp    = 8'd0;
   logic            inp_valid  = 1'b0;
   logic [8*NP-1:0] dut_outp;
   logic [NP-1:0]   outp_valid;
   logic [NP-1:0]   outp_ready = '1;
   logic            busy;
   logic [3:0]      error;
   logic [15:0]     drop_cnt;

   router_mp #(
      .NUM_PORTS(NP),
      .MIN_LEN  (12),
      .MAX_LEN  (64),
      .BUF_DEPTH(64)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .dut_inp   (dut_inp),
      .inp_valid (inp_valid),
      .dut_outp  (dut_outp),
      .outp_valid(outp_valid),
      .outp_ready(outp_ready),
      .busy      (busy),
      .error     (error),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] pkt_q[$];
   logic [7:0] exp_q[$];
   logic [3:0] err_seen[$];
   int         exp_port        = 0;
   int         exp_drop        = 0;
   int         ready_mode      = 0;
   int         pat_idx         = 0;
   int         first_valid_cyc = -1;
   int         last_acc_cyc    = -1;
   int         busy_fall_cyc   = -1;
   int         fall_cyc        = 0;
   logic       busy_prev       = 1'b0;
   logic       hold_prev       = 1'b0;
   int         hold_port       = 0;
   logic [7:0] hold_data       = 8'd0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: error code a packet must produce (0 = forward it).
   function automatic logic [3:0] model_code();
      int          n;
      int unsigned len, crc, sum;
      n = pkt_q.size();
      if (n < 12) return 4'd3;
      if (n > 64) return 4'd4;
      len = 0;
      crc = 0;
      sum = 0;
      for (int i = 0; i < 4; i++) begin
         len |= 32'(pkt_q[2+i]) << (8*i);
         crc |= 32'(pkt_q[6+i]) << (8*i);
      end
      if (len != 32'(n)) return 4'd5;
      for (int i = 10; i < n; i++) sum += 32'(pkt_q[i]);
      if (sum != crc) return 4'd2;
      if (pkt_q[1] == 8'd0 || pkt_q[1] > 8'(NP)) return 4'd6;
      return 4'd0;
   endfunction

   task automatic build_pkt(input int da, input int pl, input int len_adj, input int crc_adj);
      int unsigned sum, len, crc;
      logic [7:0]  pay[$];
      logic [7:0]  b;
      pkt_q.delete();
      sum = 0;
      for (int i = 0; i < pl; i++) begin
         b = 8'($urandom);
         pay.push_back(b);
         sum += 32'(b);
      end
      len = 32'(10 + pl + len_adj);
      crc = sum + 32'(crc_adj);
      pkt_q.push_back(8'($urandom));
      pkt_q.push_back(8'(da));
      for (int i = 0; i < 4; i++) pkt_q.push_back(8'(len >> (8*i)));
      for (int i = 0; i < 4; i++) pkt_q.push_back(8'(crc >> (8*i)));
      foreach (pay[i]) pkt_q.push_back(pay[i]);
   endtask

   task automatic drive_pkt();
      foreach (pkt_q[i]) begin
         @(posedge clk); #1;
         inp_valid = 1'b1;
         dut_inp   = pkt_q[i];
      end
      @(posedge clk); #1;
      inp_valid = 1'b0;
      dut_inp   = 8'd0;
      fall_cyc  = cyc;
   endtask

   task automatic wait_done(input string tag);
      int n;
      bit done;
      n    = 0;
      done = 1'b0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
         done = !busy && exp_q.size() == 0 && !inp_valid;
      end
      check({tag, "_done"}, 32'(done), 32'd1);
   endtask

   task automatic load_expect(input logic [3:0] code);
      if (code == 4'd0) begin
         exp_port = int'(pkt_q[1]) - 1;
         foreach (pkt_q[i]) exp_q.push_back(pkt_q[i]);
      end else if (exp_drop < 65535) begin
         exp_drop++;
      end
      err_seen.delete();
      first_valid_cyc = -1;
      busy_fall_cyc   = -1;
   endtask

   task automatic finish_pkt(input string tag, input logic [3:0] code);
      repeat (2) @(negedge clk);
      check({tag, "_nerr"}, 32'(err_seen.size()), (code == 4'd0) ? 32'd0 : 32'd1);
      if (err_seen.size() > 0) check({tag, "_code"}, 32'(err_seen[0]), 32'(code));
      check({tag, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
      check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic run_pkt(input string tag);
      logic [3:0] code;
      code = model_code();
      load_expect(code);
      drive_pkt();
      wait_done(tag);
      finish_pkt(tag, code);
   endtask

   // Output monitor: scoreboard, hold stability, idle-port zeros, error capture, backpressure.
   always @(negedge clk) begin : mon
      logic [NP-1:0] mask;
      logic [NP-1:0] rdy;
      logic [7:0]    idle_or;
      mask = (exp_q.size() != 0) ? NP'(1 << exp_port) : '0;
      check("stray_valid", 32'(outp_valid & ~mask), 32'd0);
      idle_or = 8'd0;
      for (int p = 0; p < NP; p++)
         if (!outp_valid[p]) idle_or |= dut_outp[8*p +: 8];
      check("idle_data", 32'(idle_or), 32'd0);
      if (hold_prev) begin
         check("hold_valid", 32'(outp_valid[hold_port]), 32'd1);
         check("hold_data", 32'(dut_outp[8*hold_port +: 8]), 32'(hold_data));
      end
      if (error != 4'd0) err_seen.push_back(error);
      if (busy_prev && !busy) busy_fall_cyc = cyc;
      busy_prev = busy;

      case (ready_mode)
         0:       rdy = '1;
         1:       rdy = NP'($urandom);
         default: begin
            rdy = (pat_idx % 3 == 0) ? '1 : '0;
            pat_idx++;
         end
      endcase
      outp_ready = rdy;

      hold_prev = 1'b0;
      for (int p = 0; p < NP; p++) begin
         if (outp_valid[p]) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (rdy[p]) begin
               check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0)
                  check("out_byte", 32'(dut_outp[8*p +: 8]), 32'(exp_q.pop_front()));
               last_acc_cyc = cyc;
            end else begin
               hold_prev = 1'b1;
               hold_port = p;
               hold_data = dut_outp[8*p +: 8];
            end
         end
      end
   end

   initial begin
      int         da, pl, sel, n;
      logic [3:0] code;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(outp_valid), 32'd0);
      check("rst_data", dut_outp, 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);

      // Legal packet with full-rate sink: timing of first byte, span and busy release.
      ready_mode = 0;
      build_pkt(2, 12, 0, 0);
      run_pkt("legal");
      check("legal_latency", 32'(first_valid_cyc - fall_cyc), 32'd2);
      check("legal_span", 32'(last_acc_cyc - first_valid_cyc), 32'd21);
      check("legal_busy_fall", 32'(busy_fall_cyc - last_acc_cyc), 32'd1);

      build_pkt(2, 12, 0, 1);
      run_pkt("crc");
      build_pkt(1, 1, 0, 0);
      run_pkt("short");
      build_pkt(1, 60, 0, 0);
      run_pkt("long");
      build_pkt(2, 12, 8, 0);
      run_pkt("lenfld");
      build_pkt(5, 12, 0, 0);
      run_pkt("bad_da");

      // Backpressure pattern 1,0,0 on all ports, packet to the last port.
      ready_mode = 2;
      build_pkt(4, 30, 0, 0);
      run_pkt("bp");
      ready_mode = 0;

      // Protocol violation while forwarding.
      build_pkt(3, 16, 0, 0);
      code = model_code();
      load_expect(code);
      drive_pkt();
      n = 0;
      while (outp_valid == '0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("viol_fwd_start", 32'(outp_valid != '0), 32'd1);
      @(posedge clk); #1;
      inp_valid = 1'b1;
      dut_inp   = 8'hAA;
      repeat (3) begin
         @(posedge clk); #1;
      end
      inp_valid = 1'b0;
      dut_inp   = 8'd0;
      wait_done("viol");
      finish_pkt("viol", 4'd1);

      // Asynchronous reset in the middle of reception.
      build_pkt(2, 20, 0, 0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         inp_valid = 1'b1;
         dut_inp   = pkt_q[i];
      end
      @(posedge clk); #3;
      reset     = 1'b0;
      inp_valid = 1'b0;
      dut_inp   = 8'd0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_valid", 32'(outp_valid), 32'd0);
      check("mid_rst_data", dut_outp, 32'd0);
      check("mid_rst_error", 32'(error), 32'd0);
      check("mid_rst_drop", 32'(drop_cnt), 32'd0);
      exp_drop = 0;
      @(negedge clk);
      reset = 1'b1;
      build_pkt(1, 14, 0, 0);
      run_pkt("post_rst");

      // Randomized traffic with random backpressure.
      ready_mode = 1;
      for (int k = 0; k < 24; k++) begin
         da  = int'($urandom_range(0, 5));
         pl  = int'($urandom_range(0, 60));
         sel = int'($urandom_range(0, 7));
         build_pkt(da, pl, (sel == 0) ? 3 : 0, (sel == 1) ? 1 : 0);
         run_pkt("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
